// File: rtl/pipe_stage.sv
// Valid/ready pipeline register stage with optional two-entry skid buffer,
// flush, and pause handling (hold or bubble). Invalid entries always carry zero data.
module pipe_stage #(
    parameter int unsigned DATA_W     = 134,
    parameter bit          SKID       = 1'b1,
    parameter logic [2:0]  PAUSE_LVL  = 3'd2,
    parameter bit          PAUSE_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              down_valid_o,
    input  logic              down_ready_i,
    output logic [DATA_W-1:0] down_data_o,
    input  logic              flush_i,
    input  logic [2:0]        pause_flag_i,
    output logic [1:0]        count_o
);

    logic              m_valid, m_valid_n;
    logic [DATA_W-1:0] m_data, m_data_n;
    logic              s_valid, s_valid_n;
    logic [DATA_W-1:0] s_data, s_data_n;
    logic              live;
    logic              pause;
    logic              hold;
    logic              ready_int;
    logic              up_fire;
    logic              down_fire;

    assign pause = (pause_flag_i >= PAUSE_LVL);
    assign hold  = pause && !PAUSE_MODE;

    // With the skid buffer, ready depends only on registered state.
    assign ready_int  = SKID ? !s_valid : (!m_valid || down_ready_i);
    assign up_ready_o = live && !pause && ready_int;

    assign down_valid_o = m_valid && !hold;
    assign down_data_o  = m_data;
    assign count_o      = {1'b0, m_valid} + {1'b0, s_valid};

    assign up_fire   = up_valid_i && up_ready_o;
    assign down_fire = down_valid_o && down_ready_i;

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        if (flush_i) begin
            m_valid_n = 1'b0;
            m_data_n  = '0;
            s_valid_n = 1'b0;
            s_data_n  = '0;
        end else if (down_fire) begin
            if (s_valid) begin
                m_valid_n = 1'b1;
                m_data_n  = s_data;
                s_valid_n = 1'b0;
                s_data_n  = '0;
            end else if (up_fire) begin
                m_valid_n = 1'b1;
                m_data_n  = up_data_i;
            end else begin
                m_valid_n = 1'b0;
                m_data_n  = '0;
            end
        end else if (up_fire) begin
            if (!m_valid) begin
                m_valid_n = 1'b1;
                m_data_n  = up_data_i;
            end else begin
                s_valid_n = 1'b1;
                s_data_n  = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            live    <= 1'b0;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            s_valid <= SKID ? s_valid_n : 1'b0;
            s_data  <= SKID ? s_data_n : '0;
            live    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: three configurations driven in parallel
// (skid/hold, skid/bubble, no-skid/hold) against a queue-level FIFO model.
module tb_pipe_stage;

    localparam int W = 134;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, up_valid, down_ready, flush;
    logic [2:0]    pflag;
    logic [W-1:0]  up_data;
    logic [2:0]    ur, dv;
    logic [W-1:0]  dd [3];
    logic [1:0]    cnt [3];

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage #(.DATA_W(W), .SKID(1'b1), .PAUSE_LVL(3'd2), .PAUSE_MODE(1'b0)) u_skid_hold (
        .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid), .up_ready_o(ur[0]), .up_data_i(up_data),
        .down_valid_o(dv[0]), .down_ready_i(down_ready), .down_data_o(dd[0]),
        .flush_i(flush), .pause_flag_i(pflag), .count_o(cnt[0]));

    pipe_stage #(.DATA_W(W), .SKID(1'b1), .PAUSE_LVL(3'd2), .PAUSE_MODE(1'b1)) u_skid_bubble (
        .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid), .up_ready_o(ur[1]), .up_data_i(up_data),
        .down_valid_o(dv[1]), .down_ready_i(down_ready), .down_data_o(dd[1]),
        .flush_i(flush), .pause_flag_i(pflag), .count_o(cnt[1]));

    pipe_stage #(.DATA_W(W), .SKID(1'b0), .PAUSE_LVL(3'd2), .PAUSE_MODE(1'b0)) u_reg_hold (
        .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid), .up_ready_o(ur[2]), .up_data_i(up_data),
        .down_valid_o(dv[2]), .down_ready_i(down_ready), .down_data_o(dd[2]),
        .flush_i(flush), .pause_flag_i(pflag), .count_o(cnt[2]));

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1.
    logic [W-1:0] mq [3][2];
    int           mn [3];
    bit           live;
    bit           e_v [3];
    bit           e_r [3];
    logic [W-1:0] e_d [3];
    int           e_c [3];

    function automatic bit is_skid(int k);
        return k != 2;
    endfunction

    function automatic bit is_hold(int k);
        return k != 1;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] r = '0;
        for (int i = 0; i < 5; i++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    task automatic predict();
        bit paused = (pflag >= 3'd2);
        for (int k = 0; k < 3; k++) begin
            e_v[k] = (mn[k] > 0) && !(paused && is_hold(k));
            e_d[k] = (mn[k] > 0) ? mq[k][0] : '0;
            e_r[k] = live && !paused && (is_skid(k) ? (mn[k] < 2) : (mn[k] == 0 || down_ready));
            e_c[k] = mn[k];
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                mn[k] = 0;
            end else begin
                if (e_v[k] && down_ready) begin
                    mq[k][0] = mq[k][1];
                    mn[k]--;
                end
                if (up_valid && e_r[k]) begin
                    mq[k][mn[k]] = up_data;
                    mn[k]++;
                end
            end
        end
        live = 1'b1;
    endtask

    task automatic to_sample();
        predict();
        @(negedge clk);
    endtask

    task automatic to_edge();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dv[k] !== 1'b0 || dd[k] !== '0 || ur[k] !== 1'b0 || cnt[k] !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_hold dut%0d: got v=%b r=%b c=%0d d=%h, want all zero", k, dv[k], ur[k], cnt[k], dd[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        predict();
        #1;
        n_cmp++;
        if (ur !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 000", ur);
        end
        to_edge();
        to_sample();
        n_cmp++;
        if (ur !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_first_edge_ready: got %b want 111", ur);
        end
        to_edge();
    endtask

    task automatic test_stream();
        down_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            up_valid = (i < 8);
            up_data  = W'(i + 1);
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k] || ur[k] !== e_r[k] || cnt[k] !== 2'(e_c[k])) begin
                    n_bad++;
                    $display("FAIL stream dut%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             k, dv[k], ur[k], cnt[k], dd[k], e_v[k], e_r[k], e_c[k], e_d[k]);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (dv[0] !== 1'b1 || dd[0] !== W'(i) || cnt[0] !== 2'd1) begin
                    n_bad++;
                    $display("FAIL stream_order beat%0d: got v=%b c=%0d d=%h want v=1 c=1 d=%0d", i, dv[0], cnt[0], dd[0], i);
                end
            end
            to_edge();
        end
        up_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got [4];
        int           ng = 0;
        logic [W-1:0] ea = W'(8'hA), eb = W'(8'hB), ec = W'(8'hC);
        down_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            up_valid = 1'b1;
            up_data  = (c == 0) ? ea : (c == 1) ? eb : ec;
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k] || ur[k] !== e_r[k] || cnt[k] !== 2'(e_c[k])) begin
                    n_bad++;
                    $display("FAIL stall dut%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             k, dv[k], ur[k], cnt[k], dd[k], e_v[k], e_r[k], e_c[k], e_d[k]);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (dd[0] !== ea || cnt[0] !== 2'd2 || ur[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_state: got d=%h c=%0d r=%b want d=a c=2 r=0", dd[0], cnt[0], ur[0]);
                end
            end
            to_edge();
        end
        down_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k] || ur[k] !== e_r[k] || cnt[k] !== 2'(e_c[k])) begin
                    n_bad++;
                    $display("FAIL release dut%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             k, dv[k], ur[k], cnt[k], dd[k], e_v[k], e_r[k], e_c[k], e_d[k]);
                end
            end
            if (dv[0] && ng < 4) begin
                got[ng] = dd[0];
                ng++;
            end
            to_edge();
            if (e_r[0] && up_valid) up_valid = 1'b0;
        end
        n_cmp++;
        if (ng != 3 || got[0] !== ea || got[1] !== eb || got[2] !== ec) begin
            n_bad++;
            $display("FAIL release_order: got %0d beats (%h %h %h) want 3 beats (a b c)", ng, got[0], got[1], got[2]);
        end
        n_cmp++;
        if (ur[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready: got %b want 1", ur[0]);
        end
    endtask

    task automatic test_flush();
        down_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            up_valid = 1'b1;
            up_data  = W'(8'h10 + c);
            flush    = (c == 2);
            pflag    = (c == 2) ? 3'd3 : 3'd0;
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k] || ur[k] !== e_r[k] || cnt[k] !== 2'(e_c[k])) begin
                    n_bad++;
                    $display("FAIL flush_fill dut%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             k, dv[k], ur[k], cnt[k], dd[k], e_v[k], e_r[k], e_c[k], e_d[k]);
                end
            end
            to_edge();
        end
        flush = 1'b0;
        pflag = 3'd0;
        up_valid = 1'b0;
        down_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== 1'b0 || dd[k] !== '0 || cnt[k] !== 2'd0 || ur[k] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL flush_empty dut%0d: got v=%b r=%b c=%0d d=%h want v=0 r=1 c=0 d=0", k, dv[k], ur[k], cnt[k], dd[k]);
                end
            end
            to_edge();
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] ee = W'(8'hE);
        down_ready = 1'b0;
        pflag = 3'd1;
        up_valid = 1'b1;
        up_data = ee;
        to_sample();
        n_cmp++;
        if (ur !== 3'b111) begin
            n_bad++;
            $display("FAIL pause_lvl1_ready: got %b want 111", ur);
        end
        to_edge();
        up_valid = 1'b0;
        pflag = 3'd3;
        down_ready = 1'b1;
        to_sample();
        n_cmp++;
        if (dv[0] !== 1'b0 || dd[0] !== ee || ur[0] !== 1'b0 || dv[1] !== 1'b1 || dd[1] !== ee || ur[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_enter: got hold v=%b d=%h r=%b bubble v=%b d=%h r=%b want 0/e/0 1/e/0",
                     dv[0], dd[0], ur[0], dv[1], dd[1], ur[1]);
        end
        to_edge();
        to_sample();
        n_cmp++;
        if (dv[1] !== 1'b0 || dd[1] !== '0 || cnt[1] !== 2'd0 || dd[0] !== ee || cnt[0] !== 2'd1) begin
            n_bad++;
            $display("FAIL pause_drain: got bubble v=%b d=%h c=%0d hold d=%h c=%0d want 0/0/0 e/1",
                     dv[1], dd[1], cnt[1], dd[0], cnt[0]);
        end
        to_edge();
        pflag = 3'd0;
        to_sample();
        n_cmp++;
        if (dv[0] !== 1'b1 || dd[0] !== ee || dv[2] !== 1'b1 || dd[2] !== ee) begin
            n_bad++;
            $display("FAIL pause_resume: got v=%b d=%h / v=%b d=%h want 1/e", dv[0], dd[0], dv[2], dd[2]);
        end
        to_edge();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ef = W'(8'hF);
        down_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            up_valid = 1'b1;
            up_data = rand_data();
            to_sample();
            to_edge();
        end
        n_cmp++;
        if (cnt[0] !== 2'd2) begin
            n_bad++;
            $display("FAIL reset_mid_fill: got c=%0d want 2", cnt[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dv[k] !== 1'b0 || dd[k] !== '0 || cnt[k] !== 2'd0 || ur[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_async dut%0d: got v=%b r=%b c=%0d d=%h want all zero", k, dv[k], ur[k], cnt[k], dd[k]);
            end
        end
        for (int k = 0; k < 3; k++) mn[k] = 0;
        live = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        up_valid = 1'b1;
        up_data = ef;
        down_ready = 1'b1;
        predict();
        #1;
        n_cmp++;
        if (ur !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid_release: got r=%b want 000", ur);
        end
        to_edge();
        to_sample();
        n_cmp++;
        if (ur !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_mid_ready: got r=%b want 111", ur);
        end
        to_edge();
        up_valid = 1'b0;
        to_sample();
        n_cmp++;
        if (dv !== 3'b111 || dd[0] !== ef || dd[2] !== ef) begin
            n_bad++;
            $display("FAIL reset_mid_first_beat: got v=%b d=%h want 111/f", dv, dd[0]);
        end
        to_edge();
    endtask

    task automatic test_skid0();
        bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 7; c++) begin
            up_valid = 1'b1;
            up_data = rand_data();
            down_ready = pat[c];
            to_sample();
            n_cmp++;
            if (dv[2] !== e_v[2] || dd[2] !== e_d[2] || ur[2] !== e_r[2] || cnt[2] !== 2'(e_c[2])) begin
                n_bad++;
                $display("FAIL skid0 cyc%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                         c, dv[2], ur[2], cnt[2], dd[2], e_v[2], e_r[2], e_c[2], e_d[2]);
            end
            n_cmp++;
            if (cnt[2] > 2'd1 || ur[2] !== (cnt[2] == 2'd0 || down_ready)) begin
                n_bad++;
                $display("FAIL skid0_ready cyc%0d: got r=%b c=%0d dr=%b", c, ur[2], cnt[2], down_ready);
            end
            to_edge();
        end
        up_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            up_valid = 1'($urandom);
            up_data = rand_data();
            down_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(19) == 0);
            pflag = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
            to_sample();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dv[k] !== e_v[k] || dd[k] !== e_d[k] || ur[k] !== e_r[k] || cnt[k] !== 2'(e_c[k])) begin
                    n_bad++;
                    $display("FAIL random cyc%0d dut%0d: got v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             c, k, dv[k], ur[k], cnt[k], dd[k], e_v[k], e_r[k], e_c[k], e_d[k]);
                end
            end
            to_edge();
        end
        flush = 1'b0;
        pflag = 3'd0;
        up_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        up_valid = 1'b0;
        down_ready = 1'b0;
        flush = 1'b0;
        pflag = 3'd0;
        up_data = '0;
        live = 1'b0;
        for (int k = 0; k < 3; k++) mn[k] = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_pause();
        test_reset_mid();
        test_skid0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline register stage that replaces the fixed-field, zero-on-pause stage registers between core pipeline stages, such as decode-to-execute. It carries an opaque payload of configurable width under a valid/ready handshake. An optional two-entry skid buffer gives full throughput with a registered ready. Flush and a pause level compared against the controller's pause code are supported, with a selectable hold or bubble response.

## Interface
- DATA_W, 134: payload width in bits (decode-to-execute bundle: inst, inst_addr, reg_waddr, reg_we, op1, op2).
- SKID, 1: 1 = two-entry skid buffer with registered up_ready_o; 0 = single register with combinational ready.
- PAUSE_LVL, 3'd2: stage is paused when pause_flag_i >= PAUSE_LVL (unsigned compare).
- PAUSE_MODE, 0: 0 = hold (freeze both sides); 1 = bubble (block upstream, let downstream drain).
- clk  input  1  the single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- up_valid_i  input  1  upstream payload valid.
- up_ready_o  output  1  stage can accept; a transfer occurs when up_valid_i && up_ready_o.
- up_data_i  input  DATA_W  upstream payload.
- down_valid_o  output  1  output payload valid.
- down_ready_i  input  1  downstream accepts; a transfer occurs when down_valid_o && down_ready_i.
- down_data_o  output  DATA_W  output payload.
- flush_i  input  1  discard all held and incoming beats.
- pause_flag_i  input  3  pause code from the controller.
- count_o  output  2  occupancy, 0..2 (max 1 when SKID=0).

## Operation
- State:
  - Main register: m_valid, m_data. Drives down_valid_o and down_data_o.
  - Skid register (SKID=1 only): s_valid, s_data.
- pause = (pause_flag_i >= PAUSE_LVL).
- Priority: rst_n > flush_i > pause > normal handshake.
- Reset: m_valid=0, s_valid=0, m_data=0, s_data=0. Outputs: down_valid_o=0, down_data_o=0, count_o=0, up_ready_o=0 while rst_n is low, 1 at the first edge after release.
- Flush: at the edge, m_valid and s_valid clear and both data registers load 0. Any upstream beat offered in the same cycle is dropped.
- Pause, hold mode (PAUSE_MODE=0):
  - up_ready_o=0 and down_valid_o=0, both gated combinationally.
  - All state is held, and down_data_o keeps its value.
- Pause, bubble mode (PAUSE_MODE=1):
  - up_ready_o=0.
  - The downstream side runs normally, so the stage drains; each drained beat leaves the register invalid with data zeroed.
- Normal, SKID=0:
  - up_ready_o = !m_valid || down_ready_i.
  - On an upstream transfer, m_data <= up_data_i and m_valid <= 1.
  - On a downstream transfer without an upstream transfer, m_valid <= 0 and m_data <= 0.
- Normal, SKID=1:
  - up_ready_o = !s_valid, taken from the register (no combinational path from down_ready_i).
  - Upstream transfer when main is empty, or main is draining this cycle: beat goes to main.
  - Upstream transfer when main is full and stalled: beat goes to skid.
  - Downstream transfer with skid full: skid moves to main, skid clears.
  - Ordering is strictly FIFO.
- Invalid entries always hold zero data, so a bubble is seen downstream as an all-zero payload, i.e. a NOP-equivalent.
- count_o = m_valid + s_valid.

## Timing
- Latency: one cycle from upstream transfer to down_valid_o high (main empty case).
- Throughput: one beat per cycle while down_ready_i is high, for either SKID value.
- SKID=1 stall sequence, with down_ready_i low for two cycles:
  - The first beat sits in main, the second is captured in skid.
  - up_ready_o falls the cycle after skid fills.
  - up_ready_o rises the cycle after skid empties.
- Simultaneous events:
  - Upstream and downstream transfer in the same cycle with skid empty: main reloads, count_o unchanged.
  - flush_i together with pause: the flush wins.
  - flush_i deasserted: the stage accepts again on the next edge.
- Reset mid-operation clears all state immediately (asynchronously), including an in-flight skid entry.

## Test plan
- Streaming, SKID=1: beats 0x1..0x8 on consecutive cycles, down_ready_i=1 → down_data_o delivers 0x1..0x8 in order starting one cycle later; count_o=1 throughout; no gaps.
- Backpressure, SKID=1: send 0xA, 0xB, 0xC; hold down_ready_i=0 for 3 cycles →
  - 0xA held at output, 0xB held in skid, count_o=2, up_ready_o=0.
  - After releasing down_ready_i, 0xA, 0xB, 0xC are delivered in order; up_ready_o returns to 1.
- Flush with 2 entries held plus a valid upstream beat in the same cycle → next cycle down_valid_o=0, down_data_o=0, count_o=0; the dropped beat never appears.
- Pause, PAUSE_LVL=2:
  - pause_flag_i=3'd1 → no effect.
  - pause_flag_i=3'd3 in hold mode → down_valid_o=0, data frozen; the same beat reappears when pause_flag_i returns to 0.
  - pause_flag_i=3'd3 in bubble mode → the held beat drains, then down_data_o=0 with down_valid_o=0.
- Reset: drop rst_n mid-stall with count_o=2 → outputs go to zero without waiting for a clock edge; after release, up_ready_o=1 and the first beat reaches the output in one cycle.
- SKID=0: down_ready_i toggling 1,0,1 → up_ready_o follows !m_valid || down_ready_i in the same cycle; count_o never exceeds 1.
